floor_call_register: RTL

- Receiving end of the elevator button path.
- Takes the active-high button levels from the board button handler, then synchronizes, debounces and edge-detects them.
- Latches one pending call per floor and presents the lowest-numbered pending call to the elevator controller over a valid/ready handshake.
- Drives the active-low call-lamp outputs on the board and clears a call when the controller reports that floor served.

---
 rtl/floor_call_pkg.sv | 21 ++
 rtl/floor_call_register_button_debounce.sv | 72 +++++++
 rtl/floor_call_register.sv | 116 +++++++++++
 3 files changed

// File: rtl/floor_call_pkg.sv
// Shared constants, floor index type and priority helper for the floor call path.
package floor_call_pkg;

    localparam int unsigned NUM_FLOORS_DEFAULT = 3;
    localparam int unsigned FLOOR_W            = 2;

    typedef logic [FLOOR_W-1:0] floor_idx_t;

    function automatic int unsigned lowest_set(input logic [31:0] v);
        logic found;
        lowest_set = 0;
        found      = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v[i] && !found) begin
                lowest_set = i;
                found      = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/floor_call_register_button_debounce.sv
// Two-flop synchronizer, optional debounce counter (FLOOR_CALL_DEBOUNCE_EN) and rising-edge pulse.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic stable_lvl;
    logic prev_q;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

`ifdef FLOOR_CALL_DEBOUNCE_EN
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stable_q;
    logic          stable_d;

    // The flip happens on the sample that would take the count to DEBOUNCE_CYCLES-1.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 2)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_lvl = stable_q;
`else
    assign stable_lvl = sync2_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            prev_q  <= stable_lvl;
        end
    end

    assign stable = stable_lvl;
    assign rise   = stable_lvl & ~prev_q;

endmodule

// File: rtl/floor_call_register.sv
// Floor call latch with lowest-floor valid/ready offer and active-low lamps.
// Debounce counters are built only when FLOOR_CALL_DEBOUNCE_EN is defined.
module floor_call_register
    import floor_call_pkg::*;
#(
    parameter int unsigned NUM_FLOORS      = NUM_FLOORS_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned FLOOR_W         = floor_call_pkg::FLOOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] button_in,
    input  logic                  reset_in,
    input  logic                  served_valid,
    input  logic [FLOOR_W-1:0]    served_floor,
    output logic                  call_valid,
    output logic [FLOOR_W-1:0]    call_floor,
    input  logic                  call_ready,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [NUM_FLOORS-1:0] lamp_n,
    output logic                  soft_reset
);

    if ((2 ** FLOOR_W) < NUM_FLOORS) begin : g_bad_width
        $error("FLOOR_W too narrow for NUM_FLOORS");
    end

    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] btn_stable;
    logic                  rst_stable;
    logic                  rst_rise;
    logic                  unused_stable;

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk    (clk),
            .rst    (rst),
            .raw    (button_in[g]),
            .stable (btn_stable[g]),
            .rise   (press[g])
        );
    end

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_btn (
        .clk    (clk),
        .rst    (rst),
        .raw    (reset_in),
        .stable (rst_stable),
        .rise   (rst_rise)
    );

    assign unused_stable = ^{btn_stable, rst_stable};

    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] dispatched_q, dispatched_d;
    logic                  call_valid_q, call_valid_d;
    logic [FLOOR_W-1:0]    call_floor_q, call_floor_d;
    logic                  soft_reset_q;
    logic [NUM_FLOORS-1:0] clr;
    logic [NUM_FLOORS-1:0] offer_mask;
    logic [NUM_FLOORS-1:0] avail;
    logic                  accept;

    always_comb begin
        clr        = '0;
        offer_mask = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            clr[i]        = served_valid && (served_floor == FLOOR_W'(i));
            offer_mask[i] = (call_floor_q == FLOOR_W'(i));
        end
        accept = call_valid_q && call_ready;

        // Clear is applied after set so a same-cycle press on a served floor is dropped.
        pending_d = (pending_q | press) & ~clr;
        if (rst_rise) begin
            pending_d = '0;
        end
        dispatched_d = (dispatched_q | (accept ? offer_mask : '0)) & pending_d;

        // The accepted floor is masked here because its dispatched bit lands only at this edge.
        avail = pending_q & ~dispatched_q & ~clr & ~(accept ? offer_mask : '0);

        call_valid_d = |avail;
        call_floor_d = FLOOR_W'(lowest_set(32'(avail)));
        if (rst_rise) begin
            call_valid_d = 1'b0;
            call_floor_d = '0;
        end else if (call_valid_q && !call_ready && !(|(offer_mask & clr))) begin
            call_valid_d = 1'b1;
            call_floor_d = call_floor_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            dispatched_q <= '0;
            call_valid_q <= 1'b0;
            call_floor_q <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            dispatched_q <= dispatched_d;
            call_valid_q <= call_valid_d;
            call_floor_q <= call_floor_d;
            soft_reset_q <= rst_rise;
        end
    end

    assign pending    = pending_q;
    assign lamp_n     = ~pending_q;
    assign call_valid = call_valid_q;
    assign call_floor = call_floor_q;
    assign soft_reset = soft_reset_q;

endmodule
